// File: rtl/axi_cache_64_pkg.sv
// Shared widths, read FSM states and the captured AR request record for the
// 64-bit direct-mapped read cache.
package axi_cache_64_pkg;
    localparam int ID_W   = 6;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 8;

    localparam logic [1:0] AXI_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, MISS_AR, MISS_R, BYP_AR, BYP_R, RESP
    } rd_state_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        region;
        logic [3:0]        qos;
    } ar_req_t;
endpackage

// File: rtl/axi_cache_64_store.sv
// Tag/data/valid storage for the direct-mapped cache. Lines are addressed by
// addr[ADDR_W-1:3]; low bits index the line, high bits form the tag.
module axi_cache_64_store import axi_cache_64_pkg::*; #(
    parameter int LINES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-4:0] rd_line,
    output logic              hit,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-4:0] wr_line,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              inv_en,
    input  logic [ADDR_W-4:0] inv_line,
    input  logic              flush
);
    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 3 - IDX;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [DATA_W-1:0] data [LINES];

    logic [IDX-1:0] rd_idx, wr_idx, inv_idx;
    assign rd_idx  = rd_line[IDX-1:0];
    assign wr_idx  = wr_line[IDX-1:0];
    assign inv_idx = inv_line[IDX-1:0];

    assign hit     = valid[rd_idx] && (tags[rd_idx] == rd_line[ADDR_W-4:IDX]);
    assign rd_data = data[rd_idx];

    // Invalidation is applied after install so it wins on a same-cycle clash.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (wr_en)
                valid[wr_idx] <= 1'b1;
            if (flush)
                valid <= '0;
            else if (inv_en && tags[inv_idx] == inv_line[ADDR_W-4:IDX])
                valid[inv_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_line[ADDR_W-4:IDX];
            data[wr_idx] <= wr_data;
        end
    end
endmodule

// File: rtl/axi_cache_64.sv
// Write-through, no-write-allocate read cache between a CPU AXI4 master and
// memory. Single-beat reads are cached; bursts and writes pass straight through.
module axi_cache_64 import axi_cache_64_pkg::*; #(
    parameter int LINES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic [ID_W-1:0] icpu_aw_id, input logic [ADDR_W-1:0] icpu_aw_addr,
    input  logic [LEN_W-1:0] icpu_aw_len, input logic [2:0] icpu_aw_size,
    input  logic [1:0] icpu_aw_burst, input logic icpu_aw_lock, input logic [3:0] icpu_aw_cache,
    input  logic [2:0] icpu_aw_prot, input logic [3:0] icpu_aw_region, input logic [3:0] icpu_aw_qos,
    input  logic icpu_aw_valid, output logic ocpu_aw_ready,
    input  logic [ID_W-1:0] icpu_ar_id, input logic [ADDR_W-1:0] icpu_ar_addr,
    input  logic [LEN_W-1:0] icpu_ar_len, input logic [2:0] icpu_ar_size,
    input  logic [1:0] icpu_ar_burst, input logic icpu_ar_lock, input logic [3:0] icpu_ar_cache,
    input  logic [2:0] icpu_ar_prot, input logic [3:0] icpu_ar_region, input logic [3:0] icpu_ar_qos,
    input  logic icpu_ar_valid, output logic ocpu_ar_ready,
    input  logic [DATA_W-1:0] icpu_w_data, input logic [7:0] icpu_w_strb,
    input  logic icpu_w_last, input logic icpu_w_valid, output logic ocpu_w_ready,
    output logic [ID_W-1:0] ocpu_b_id, output logic [1:0] ocpu_b_resp,
    output logic ocpu_b_valid, input logic icpu_b_ready,
    output logic [ID_W-1:0] ocpu_r_id, output logic [DATA_W-1:0] ocpu_r_data,
    output logic [1:0] ocpu_r_resp, output logic ocpu_r_last, output logic ocpu_r_valid,
    input  logic icpu_r_ready,
    output logic [ID_W-1:0] o_aw_id, output logic [ADDR_W-1:0] o_aw_addr,
    output logic [LEN_W-1:0] o_aw_len, output logic [2:0] o_aw_size,
    output logic [1:0] o_aw_burst, output logic o_aw_lock, output logic [3:0] o_aw_cache,
    output logic [2:0] o_aw_prot, output logic [3:0] o_aw_region, output logic [3:0] o_aw_qos,
    output logic o_aw_valid, input logic i_aw_ready,
    output logic [ID_W-1:0] o_ar_id, output logic [ADDR_W-1:0] o_ar_addr,
    output logic [LEN_W-1:0] o_ar_len, output logic [2:0] o_ar_size,
    output logic [1:0] o_ar_burst, output logic o_ar_lock, output logic [3:0] o_ar_cache,
    output logic [2:0] o_ar_prot, output logic [3:0] o_ar_region, output logic [3:0] o_ar_qos,
    output logic o_ar_valid, input logic i_ar_ready,
    output logic [DATA_W-1:0] o_w_data, output logic [7:0] o_w_strb,
    output logic o_w_last, output logic o_w_valid, input logic i_w_ready,
    input  logic [ID_W-1:0] i_b_id, input logic [1:0] i_b_resp,
    input  logic i_b_valid, output logic o_b_ready,
    input  logic [ID_W-1:0] i_r_id, input logic [DATA_W-1:0] i_r_data,
    input  logic [1:0] i_r_resp, input logic i_r_last, input logic i_r_valid,
    output logic o_r_ready
);
    localparam int IDX = $clog2(LINES);

    rd_state_t         state, state_nxt;
    ar_req_t           ar_q;
    logic [ID_W-1:0]   r_id_q;
    logic [DATA_W-1:0] r_data_q;
    logic [1:0]        r_resp_q;
    logic              inv_seen;
    logic              st_hit, aw_hs, flush, aw_idx_hit, ar_hs, hit, install;
    logic [DATA_W-1:0] st_data;

    assign o_aw_id = icpu_aw_id;         assign o_aw_addr = icpu_aw_addr;
    assign o_aw_len = icpu_aw_len;       assign o_aw_size = icpu_aw_size;
    assign o_aw_burst = icpu_aw_burst;   assign o_aw_lock = icpu_aw_lock;
    assign o_aw_cache = icpu_aw_cache;   assign o_aw_prot = icpu_aw_prot;
    assign o_aw_region = icpu_aw_region; assign o_aw_qos = icpu_aw_qos;
    assign o_aw_valid = icpu_aw_valid;   assign ocpu_aw_ready = i_aw_ready;
    assign o_w_data = icpu_w_data;       assign o_w_strb = icpu_w_strb;
    assign o_w_last = icpu_w_last;       assign o_w_valid = icpu_w_valid;
    assign ocpu_w_ready = i_w_ready;
    assign ocpu_b_id = i_b_id;           assign ocpu_b_resp = i_b_resp;
    assign ocpu_b_valid = i_b_valid;     assign o_b_ready = icpu_b_ready;

    assign o_ar_id = ar_q.id;            assign o_ar_addr = ar_q.addr;
    assign o_ar_len = ar_q.len;          assign o_ar_size = ar_q.size;
    assign o_ar_burst = ar_q.burst;      assign o_ar_lock = ar_q.lock;
    assign o_ar_cache = ar_q.cache;      assign o_ar_prot = ar_q.prot;
    assign o_ar_region = ar_q.region;    assign o_ar_qos = ar_q.qos;

    assign aw_hs      = icpu_aw_valid & i_aw_ready;
    assign flush      = aw_hs & (icpu_aw_len != '0);
    // Any write touching the pending read's index poisons the fill and the hit.
    assign aw_idx_hit = aw_hs & ((icpu_aw_len != '0) |
                                 (icpu_aw_addr[3 +: IDX] == ar_q.addr[3 +: IDX]));
    assign ar_hs      = (state == IDLE) & icpu_ar_valid;
    assign hit        = st_hit & ~aw_idx_hit;
    assign install    = (state == MISS_R) & i_r_valid & (i_r_resp == AXI_OKAY) &
                        ~inv_seen & ~aw_idx_hit;

    axi_cache_64_store #(.LINES(LINES)) u_store (
        .clk(clk), .rst(rst),
        .rd_line(ar_q.addr[ADDR_W-1:3]), .hit(st_hit), .rd_data(st_data),
        .wr_en(install), .wr_line(ar_q.addr[ADDR_W-1:3]), .wr_data(i_r_data),
        .inv_en(aw_hs & (icpu_aw_len == '0)), .inv_line(icpu_aw_addr[ADDR_W-1:3]),
        .flush(flush)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            inv_seen <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ar_hs)
                inv_seen <= aw_hs & ((icpu_aw_len != '0) |
                                     (icpu_aw_addr[3 +: IDX] == icpu_ar_addr[3 +: IDX]));
            else if (aw_idx_hit)
                inv_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ar_hs)
            ar_q <= '{id: icpu_ar_id, addr: icpu_ar_addr, len: icpu_ar_len,
                      size: icpu_ar_size, burst: icpu_ar_burst, lock: icpu_ar_lock,
                      cache: icpu_ar_cache, prot: icpu_ar_prot,
                      region: icpu_ar_region, qos: icpu_ar_qos};
        if (state == LOOKUP && hit) begin
            r_data_q <= st_data;
            r_resp_q <= AXI_OKAY;
            r_id_q   <= ar_q.id;
        end else if (state == MISS_R && i_r_valid) begin
            r_data_q <= i_r_data;
            r_resp_q <= i_r_resp;
            r_id_q   <= i_r_id;
        end
    end

    always_comb begin
        state_nxt     = state;
        ocpu_ar_ready = 1'b0;
        o_ar_valid    = 1'b0;
        o_r_ready     = 1'b0;
        ocpu_r_valid  = 1'b0;
        ocpu_r_id     = r_id_q;
        ocpu_r_data   = r_data_q;
        ocpu_r_resp   = r_resp_q;
        ocpu_r_last   = 1'b1;
        case (state)
            IDLE: begin
                ocpu_ar_ready = 1'b1;
                if (icpu_ar_valid) state_nxt = (icpu_ar_len == '0) ? LOOKUP : BYP_AR;
            end
            LOOKUP:  state_nxt = hit ? RESP : MISS_AR;
            MISS_AR: begin
                o_ar_valid = 1'b1;
                if (i_ar_ready) state_nxt = MISS_R;
            end
            BYP_AR: begin
                o_ar_valid = 1'b1;
                if (i_ar_ready) state_nxt = BYP_R;
            end
            MISS_R: begin
                o_r_ready = 1'b1;
                if (i_r_valid) state_nxt = RESP;
            end
            BYP_R: begin
                o_r_ready    = icpu_r_ready;
                ocpu_r_valid = i_r_valid;
                ocpu_r_id    = i_r_id;
                ocpu_r_data  = i_r_data;
                ocpu_r_resp  = i_r_resp;
                ocpu_r_last  = i_r_last;
                if (i_r_valid && icpu_r_ready && i_r_last) state_nxt = IDLE;
            end
            RESP: begin
                ocpu_r_valid = 1'b1;
                if (icpu_r_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_cache_64.sv
// Self-checking bench for axi_cache_64: directed vector table, reset-abort
// sequence, and randomized traffic against a line-level cache/memory model.
module tb_axi_cache_64;
    logic clk = 1'b0, rst;
    logic [5:0] icpu_aw_id, icpu_ar_id, ocpu_b_id, ocpu_r_id, o_aw_id, o_ar_id, i_b_id, i_r_id;
    logic [31:0] icpu_aw_addr, icpu_ar_addr, o_aw_addr, o_ar_addr;
    logic [7:0] icpu_aw_len, icpu_ar_len, o_aw_len, o_ar_len, icpu_w_strb, o_w_strb;
    logic [2:0] icpu_aw_size, icpu_ar_size, o_aw_size, o_ar_size;
    logic [1:0] icpu_aw_burst, icpu_ar_burst, o_aw_burst, o_ar_burst;
    logic icpu_aw_lock, icpu_ar_lock, o_aw_lock, o_ar_lock;
    logic [3:0] icpu_aw_cache, icpu_ar_cache, o_aw_cache, o_ar_cache;
    logic [2:0] icpu_aw_prot, icpu_ar_prot, o_aw_prot, o_ar_prot;
    logic [3:0] icpu_aw_region, icpu_ar_region, o_aw_region, o_ar_region;
    logic [3:0] icpu_aw_qos, icpu_ar_qos, o_aw_qos, o_ar_qos;
    logic icpu_aw_valid, ocpu_aw_ready, icpu_ar_valid, ocpu_ar_ready;
    logic [63:0] icpu_w_data, o_w_data, ocpu_r_data, i_r_data;
    logic icpu_w_last, icpu_w_valid, ocpu_w_ready, o_w_last, o_w_valid, i_w_ready;
    logic [1:0] ocpu_b_resp, ocpu_r_resp, i_b_resp, i_r_resp;
    logic ocpu_b_valid, icpu_b_ready, ocpu_r_last, ocpu_r_valid, icpu_r_ready;
    logic o_aw_valid, i_aw_ready, o_ar_valid, i_ar_ready, i_b_valid, o_b_ready;
    logic i_r_last, i_r_valid, o_r_ready;

    axi_cache_64 #(.LINES(64)) dut (
        .clk(clk), .rst(rst),
        .icpu_aw_id(icpu_aw_id), .icpu_aw_addr(icpu_aw_addr), .icpu_aw_len(icpu_aw_len),
        .icpu_aw_size(icpu_aw_size), .icpu_aw_burst(icpu_aw_burst), .icpu_aw_lock(icpu_aw_lock),
        .icpu_aw_cache(icpu_aw_cache), .icpu_aw_prot(icpu_aw_prot), .icpu_aw_region(icpu_aw_region),
        .icpu_aw_qos(icpu_aw_qos), .icpu_aw_valid(icpu_aw_valid), .ocpu_aw_ready(ocpu_aw_ready),
        .icpu_ar_id(icpu_ar_id), .icpu_ar_addr(icpu_ar_addr), .icpu_ar_len(icpu_ar_len),
        .icpu_ar_size(icpu_ar_size), .icpu_ar_burst(icpu_ar_burst), .icpu_ar_lock(icpu_ar_lock),
        .icpu_ar_cache(icpu_ar_cache), .icpu_ar_prot(icpu_ar_prot), .icpu_ar_region(icpu_ar_region),
        .icpu_ar_qos(icpu_ar_qos), .icpu_ar_valid(icpu_ar_valid), .ocpu_ar_ready(ocpu_ar_ready),
        .icpu_w_data(icpu_w_data), .icpu_w_strb(icpu_w_strb), .icpu_w_last(icpu_w_last),
        .icpu_w_valid(icpu_w_valid), .ocpu_w_ready(ocpu_w_ready),
        .ocpu_b_id(ocpu_b_id), .ocpu_b_resp(ocpu_b_resp), .ocpu_b_valid(ocpu_b_valid),
        .icpu_b_ready(icpu_b_ready),
        .ocpu_r_id(ocpu_r_id), .ocpu_r_data(ocpu_r_data), .ocpu_r_resp(ocpu_r_resp),
        .ocpu_r_last(ocpu_r_last), .ocpu_r_valid(ocpu_r_valid), .icpu_r_ready(icpu_r_ready),
        .o_aw_id(o_aw_id), .o_aw_addr(o_aw_addr), .o_aw_len(o_aw_len), .o_aw_size(o_aw_size),
        .o_aw_burst(o_aw_burst), .o_aw_lock(o_aw_lock), .o_aw_cache(o_aw_cache),
        .o_aw_prot(o_aw_prot), .o_aw_region(o_aw_region), .o_aw_qos(o_aw_qos),
        .o_aw_valid(o_aw_valid), .i_aw_ready(i_aw_ready),
        .o_ar_id(o_ar_id), .o_ar_addr(o_ar_addr), .o_ar_len(o_ar_len), .o_ar_size(o_ar_size),
        .o_ar_burst(o_ar_burst), .o_ar_lock(o_ar_lock), .o_ar_cache(o_ar_cache),
        .o_ar_prot(o_ar_prot), .o_ar_region(o_ar_region), .o_ar_qos(o_ar_qos),
        .o_ar_valid(o_ar_valid), .i_ar_ready(i_ar_ready),
        .o_w_data(o_w_data), .o_w_strb(o_w_strb), .o_w_last(o_w_last), .o_w_valid(o_w_valid),
        .i_w_ready(i_w_ready),
        .i_b_id(i_b_id), .i_b_resp(i_b_resp), .i_b_valid(i_b_valid), .o_b_ready(o_b_ready),
        .i_r_id(i_r_id), .i_r_data(i_r_data), .i_r_resp(i_r_resp), .i_r_last(i_r_last),
        .i_r_valid(i_r_valid), .o_r_ready(o_r_ready)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    // Memory contents and the expected set of resident lines (64 lines, 8-byte).
    logic [63:0] mem [logic [31:0]];
    bit          mv [64];
    logic [22:0] mt [64];

    // Results of the most recent cpu_read.
    int n_ar, n_beats, first_rv;
    logic [31:0] ar_addr_seen; logic [7:0] ar_len_seen; logic [5:0] ar_id_seen;
    logic [2:0] ar_prot_seen;
    logic [63:0] got_data [4]; logic [1:0] got_resp [4]; logic [5:0] got_id [4];
    logic got_last [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a ^ 32'h5A5A_0F0F, ~a};
    endfunction

    task automatic cpu_read(input logic [31:0] addr, input logic [7:0] len, input logic [5:0] id,
                            input int lat, input logic [1:0] mresp);
        int ar_cyc, mem_beats, mem_idx, mem_wait;
        bit ar_done;
        n_ar = 0; n_beats = 0; first_rv = -1; ar_done = 0; ar_cyc = 0;
        mem_beats = 0; mem_idx = 0; mem_wait = 0;
        @(negedge clk);
        icpu_ar_addr = addr; icpu_ar_len = len; icpu_ar_id = id; icpu_ar_prot = 3'b010;
        icpu_ar_valid = 1'b1; icpu_r_ready = 1'b1; i_ar_ready = 1'b1; i_r_valid = 1'b0;
        for (int t = 0; t < 300 && n_beats < int'(len) + 1; t++) begin
            #1;
            if (!ar_done && ocpu_ar_ready) begin ar_done = 1; ar_cyc = t; end
            if (o_ar_valid && i_ar_ready) begin
                n_ar++; ar_addr_seen = o_ar_addr; ar_len_seen = o_ar_len; ar_id_seen = o_ar_id;
                ar_prot_seen = o_ar_prot;
                mem_beats = int'(o_ar_len) + 1; mem_idx = 0; mem_wait = lat;
            end
            if (i_r_valid && o_r_ready) mem_idx++;
            if (ocpu_r_valid && icpu_r_ready && n_beats < 4) begin
                if (n_beats == 0) first_rv = t - ar_cyc;
                got_data[n_beats] = ocpu_r_data; got_resp[n_beats] = ocpu_r_resp;
                got_id[n_beats] = ocpu_r_id; got_last[n_beats] = ocpu_r_last;
                n_beats++;
            end
            @(posedge clk); @(negedge clk);
            if (ar_done) icpu_ar_valid = 1'b0;
            i_r_valid = 1'b0;
            if (mem_idx < mem_beats) begin
                if (mem_wait > 0) mem_wait--;
                else begin
                    i_r_valid = 1'b1; i_r_id = ar_id_seen; i_r_resp = mresp;
                    i_r_data = mem_rd(ar_addr_seen + 32'(mem_idx) * 8);
                    i_r_last = (mem_idx == mem_beats - 1);
                end
            end
        end
        icpu_ar_valid = 1'b0; i_r_valid = 1'b0;
    endtask

    task automatic check_read(input logic [31:0] addr, input logic [7:0] len, input logic [5:0] id,
                              input int exp_ar, input logic [1:0] exp_resp, input int exp_rv);
        chk("n_ar", n_ar, exp_ar);
        if (exp_ar > 0) begin
            chk("ar_addr", ar_addr_seen, addr);
            chk("ar_len", ar_len_seen, len);
            chk("ar_prot", ar_prot_seen, 3'b010);
        end
        chk("r_beats", n_beats, int'(len) + 1);
        for (int i = 0; i <= int'(len) && i < 4; i++) begin
            chk("r_data", got_data[i], mem_rd(addr + 32'(i) * 8));
            chk("r_last", got_last[i], (i == int'(len)));
            chk("r_resp", got_resp[i], exp_resp);
            chk("r_id", got_id[i], id);
        end
        if (exp_rv >= 0) chk("hit_latency", first_rv, exp_rv);
    endtask

    task automatic model_read(input logic [31:0] a, input logic [7:0] len, input logic [1:0] mresp);
        if (len == 0 && mresp == 2'b00) begin mv[a[8:3]] = 1; mt[a[8:3]] = a[31:9]; end
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [7:0] len,
                             input logic [63:0] data, input logic [7:0] strb, input logic [5:0] id);
        logic [63:0] m;
        @(negedge clk);
        icpu_aw_addr = addr; icpu_aw_len = len; icpu_aw_id = id; icpu_aw_prot = 3'b011;
        icpu_aw_valid = 1'b1; icpu_w_data = data; icpu_w_strb = strb;
        icpu_w_last = (len == 0); icpu_w_valid = 1'b1; i_aw_ready = 1'b1; i_w_ready = 1'b1;
        #1;
        chk("aw_addr", o_aw_addr, addr); chk("aw_len", o_aw_len, len);
        chk("aw_id", o_aw_id, id); chk("aw_prot", o_aw_prot, 3'b011);
        chk("aw_valid", o_aw_valid, 1'b1); chk("w_data", o_w_data, data);
        chk("w_strb", o_w_strb, strb); chk("w_last", o_w_last, (len == 0));
        chk("aw_ready", ocpu_aw_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        icpu_aw_valid = 1'b0; icpu_w_valid = 1'b0;
        i_b_valid = 1'b1; i_b_id = id ^ 6'h15; i_b_resp = 2'b01; icpu_b_ready = 1'b1;
        #1;
        chk("b_valid", ocpu_b_valid, 1'b1); chk("b_id", ocpu_b_id, id ^ 6'h15);
        chk("b_resp", ocpu_b_resp, 2'b01); chk("b_ready", o_b_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        i_b_valid = 1'b0;
        if (len == 0) begin
            m = mem_rd(addr);
            for (int b = 0; b < 8; b++) if (strb[b]) m[b*8 +: 8] = data[b*8 +: 8];
            mem[addr] = m;
            if (mv[addr[8:3]] && mt[addr[8:3]] == addr[31:9]) mv[addr[8:3]] = 0;
        end else begin
            for (int i = 0; i < 64; i++) mv[i] = 0;
        end
    endtask

    typedef struct {
        bit wr; logic [31:0] addr; logic [7:0] len; logic [5:0] id; int lat;
        logic [1:0] mresp; int exp_ar; logic [1:0] exp_resp; int exp_rv; logic [63:0] wdata;
    } vec_t;
    vec_t tbl [14];

    initial begin
        logic [31:0] a; logic [7:0] ln; logic [1:0] mr; int op; bit hit;
        rst = 1'b1;
        {icpu_aw_id, icpu_aw_addr, icpu_aw_len, icpu_aw_lock, icpu_aw_cache, icpu_aw_prot,
         icpu_aw_region, icpu_aw_valid} = '0;
        {icpu_ar_id, icpu_ar_addr, icpu_ar_len, icpu_ar_lock, icpu_ar_cache, icpu_ar_prot,
         icpu_ar_region, icpu_ar_valid} = '0;
        icpu_aw_size = 3'd3; icpu_ar_size = 3'd3; icpu_aw_burst = 2'd1; icpu_ar_burst = 2'd1;
        icpu_aw_qos = 4'h3; icpu_ar_qos = 4'h3;
        {icpu_w_data, icpu_w_strb, icpu_w_last, icpu_w_valid} = '0;
        icpu_b_ready = 1'b1; icpu_r_ready = 1'b1;
        i_aw_ready = 1'b1; i_ar_ready = 1'b1; i_w_ready = 1'b1;
        {i_b_id, i_b_resp, i_b_valid, i_r_id, i_r_data, i_r_resp, i_r_last, i_r_valid} = '0;
        for (int i = 0; i < 64; i++) begin mv[i] = 0; mt[i] = '0; end
        mem[32'h100] = 64'h1122_3344_5566_7788;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_ar_ready", ocpu_ar_ready, 1'b1); chk("rst_r_valid", ocpu_r_valid, 1'b0);
        chk("rst_o_ar_valid", o_ar_valid, 1'b0); chk("rst_o_r_ready", o_r_ready, 1'b0);

        tbl[0]  = '{0, 32'h100, 0, 6'd5, 2, 2'd0, 1, 2'd0, -1, 64'd0};
        tbl[1]  = '{0, 32'h100, 0, 6'd6, 2, 2'd0, 0, 2'd0,  2, 64'd0};
        tbl[2]  = '{1, 32'h100, 0, 6'd7, 0, 2'd0, 0, 2'd0, -1, 64'hDEAD_BEEF_CAFE_F00D};
        tbl[3]  = '{0, 32'h100, 0, 6'd8, 1, 2'd0, 1, 2'd0, -1, 64'd0};
        tbl[4]  = '{0, 32'h100, 0, 6'd9, 0, 2'd0, 0, 2'd0,  2, 64'd0};
        tbl[5]  = '{0, 32'h300, 0, 6'd10, 0, 2'd0, 1, 2'd0, -1, 64'd0};
        tbl[6]  = '{0, 32'h100, 0, 6'd11, 3, 2'd0, 1, 2'd0, -1, 64'd0};
        tbl[7]  = '{0, 32'h200, 3, 6'd12, 1, 2'd0, 1, 2'd0, -1, 64'd0};
        tbl[8]  = '{0, 32'h200, 0, 6'd13, 0, 2'd0, 1, 2'd0, -1, 64'd0};
        tbl[9]  = '{0, 32'h208, 0, 6'd14, 1, 2'd2, 1, 2'd2, -1, 64'd0};
        tbl[10] = '{0, 32'h208, 0, 6'd15, 1, 2'd0, 1, 2'd0, -1, 64'd0};
        tbl[11] = '{0, 32'h208, 0, 6'd16, 0, 2'd0, 0, 2'd0,  2, 64'd0};
        tbl[12] = '{1, 32'h040, 3, 6'd17, 0, 2'd0, 0, 2'd0, -1, 64'h0123_4567_89AB_CDEF};
        tbl[13] = '{0, 32'h208, 0, 6'd18, 2, 2'd0, 1, 2'd0, -1, 64'd0};
        for (int v = 0; v < 14; v++) begin
            if (tbl[v].wr) cpu_write(tbl[v].addr, tbl[v].len, tbl[v].wdata, 8'hFF, tbl[v].id);
            else begin
                cpu_read(tbl[v].addr, tbl[v].len, tbl[v].id, tbl[v].lat, tbl[v].mresp);
                check_read(tbl[v].addr, tbl[v].len, tbl[v].id, tbl[v].exp_ar,
                           tbl[v].exp_resp, tbl[v].exp_rv);
                if (n_ar > 0) model_read(tbl[v].addr, tbl[v].len, tbl[v].mresp);
            end
        end

        // Reset while the cache waits on memory: transaction dropped, lines lost.
        cpu_read(32'h300, 0, 6'd20, 0, 2'd0); check_read(32'h300, 0, 6'd20, 1, 2'd0, -1);
        cpu_read(32'h300, 0, 6'd21, 0, 2'd0); check_read(32'h300, 0, 6'd21, 0, 2'd0, 2);
        @(negedge clk);
        icpu_ar_addr = 32'h480; icpu_ar_len = 0; icpu_ar_id = 6'd22; icpu_ar_valid = 1'b1;
        @(posedge clk); @(negedge clk); icpu_ar_valid = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        chk("rst_seq_ar_valid", o_ar_valid, 1'b1);
        @(posedge clk); @(negedge clk); #1;
        chk("rst_seq_in_miss_r", o_r_ready, 1'b1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk); rst = 1'b0; #1;
        chk("rst_seq_r_valid", ocpu_r_valid, 1'b0); chk("rst_seq_r_ready", o_r_ready, 1'b0);
        chk("rst_seq_idle", ocpu_ar_ready, 1'b1); chk("rst_seq_o_ar", o_ar_valid, 1'b0);
        for (int i = 0; i < 64; i++) mv[i] = 0;
        cpu_read(32'h300, 0, 6'd23, 1, 2'd0); check_read(32'h300, 0, 6'd23, 1, 2'd0, -1);
        model_read(32'h300, 0, 2'd0);

        for (int k = 0; k < 150; k++) begin
            op = int'($urandom_range(0, 99));
            a = 32'($urandom_range(0, 2)) * 32'd512 + 32'($urandom_range(0, 15)) * 32'd8;
            if (op < 20) cpu_write(a, 0, {$urandom, $urandom}, 8'($urandom), 6'($urandom));
            else if (op < 24) cpu_write(a, 8'($urandom_range(1, 7)), {$urandom, $urandom}, 8'hFF, 6'd1);
            else begin
                ln = (op < 36) ? 8'($urandom_range(1, 3)) : 8'd0;
                mr = ($urandom_range(0, 9) == 0) ? 2'd2 : 2'd0;
                hit = (ln == 0) && mv[a[8:3]] && mt[a[8:3]] == a[31:9];
                cpu_read(a, ln, 6'($urandom), int'($urandom_range(0, 3)), mr);
                check_read(a, ln, got_id[0] == got_id[0] ? icpu_ar_id : 6'd0,
                           hit ? 0 : 1, hit ? 2'd0 : mr, hit ? 2 : -1);
                if (!hit) model_read(a, ln, mr);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
